alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Operand-fetch stage directly upstream of the ALU. Holds the architectural register file, reads two source operands (or one register plus a sign-extended immediate) per instruction, and forwards a same-cycle writeback. It presents a registered aluOp/inA/inB bundle to the ALU through a valid/ready handshake with a 2-entry skid buffer, so upstream never sees a combinational path from ALU-side backpressure.

## Interface
- OPCODE_BIT_WIDTH, 4, width of the ALU opcode passed through unchanged
- DBITS, 32, datapath width
- REG_INDEX_BIT_WIDTH, 4, register index width (2^N registers)
- IMM_BITS, 16, immediate width, sign-extended to DBITS
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; registered
- in_aluOp  in  OPCODE_BIT_WIDTH  opcode for the ALU
- in_rs1, in_rs2  in  REG_INDEX_BIT_WIDTH  source register indices
- in_imm  in  IMM_BITS  immediate
- in_useImm  in  1  1: inB = sext(in_imm), rs2 ignored
- wb_en  in  1  register write enable
- wb_idx  in  REG_INDEX_BIT_WIDTH  write index
- wb_data  in  DBITS  write data
- out_valid  out  1  bundle valid to ALU
- out_ready  in  1  ALU side accepts
- out_aluOp  out  OPCODE_BIT_WIDTH  registered opcode
- out_inA, out_inB  out  DBITS  registered operands

## Operation
- Register file: 2^REG_INDEX_BIT_WIDTH × DBITS, all zero on reset; write on clk when wb_en.
- Reads are combinational with bypass: if wb_en and wb_idx equals the source index, the operand is wb_data, not the stored value.
- inA = R[rs1]; inB = in_useImm ? {sign-extend in_imm} : R[rs2]. Sign extension replicates in_imm[IMM_BITS-1].
- Operands are sampled at acceptance (in_valid && in_ready). Later writes do not update captured bundles; hazard stalling belongs upstream.
- Two bundle slots: OUT (drives outputs) and SKID. States: EMPTY, ONE (OUT full), TWO (OUT and SKID full).
  - EMPTY: accept → ONE.
  - ONE: accept without out_ready → TWO; out_ready without accept → EMPTY; both → ONE with OUT replaced by the new bundle.
  - TWO: out_ready → OUT takes SKID, → ONE; no accept possible.
- in_ready = (state != TWO), registered. out_valid = (state != EMPTY).
- Order preserved: SKID always younger than OUT.

## Timing
- Reset (async assert, sync release): state EMPTY, out_valid 0, in_ready 1, out_aluOp/out_inA/out_inB 0, all registers 0.
- Latency: accept in cycle N → out_valid and data in cycle N+1.
- Throughput: one bundle per cycle while out_ready is high.
- out_* stable while out_valid && !out_ready.
- Reset mid-operation discards both slots; no partial bundle is emitted after release.
- Write and read of the same index in the same cycle: the bypassed value is captured and the register file is updated. Both are visible.

## Configuration
- ZERO_REG_EN defined: register 0 reads 0, writes to index 0 are dropped, and no bypass occurs for index 0.
- Undefined: register 0 is an ordinary register.

## Structure
- Shared package: parameter defaults, state encoding (EMPTY/ONE/TWO), and the bundle struct {aluOp, inA, inB} used by both slots.
- One sub-module: alu_regfile, with 2 combinational read ports, 1 write port, bypass, and ZERO_REG_EN handling.

## Test plan
- Reset, then write R3=0x0000_00AA and R5=0x0000_0055; issue rs1=3, rs2=5, aluOp=4'b0001 → next cycle out_inA=0xAA, out_inB=0x55, out_aluOp=0001, out_valid=1.
- in_useImm=1, in_imm=0x8001, rs1=3 → out_inB=0xFFFF_8001.
- Same cycle wb_en, wb_idx=7, wb_data=0x1234 and issue rs1=7 → out_inA=0x1234; a later read of R7 also gives 0x1234.
- out_ready=0, issue 3 back-to-back instructions → in_ready drops after the 2nd accept; raise out_ready → bundles emerge in order 1, 2, 3 with no loss or duplication.
- Streaming with out_ready=1 → one bundle per cycle, in_ready never drops.
- ZERO_REG_EN: write R0=0xFFFF and read rs1=0 → out_inA=0. Without the macro → 0xFFFF. Assert rst_n with state TWO → out_valid=0 and in_ready=1 immediately.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg
//   Shared definitions for the ALU operand-fetch stage: default widths,
//   output-buffer occupancy encoding and the operand bundle held by both
//   the OUT and SKID slots.
package alu_operand_stage_pkg;

  localparam int unsigned DEF_OPCODE_BIT_WIDTH    = 4;
  localparam int unsigned DEF_DBITS               = 32;
  localparam int unsigned DEF_REG_INDEX_BIT_WIDTH = 4;
  localparam int unsigned DEF_IMM_BITS            = 16;

  // Occupancy of the two-slot output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [DEF_OPCODE_BIT_WIDTH-1:0] aluOp;
    logic [DEF_DBITS-1:0]            inA;
    logic [DEF_DBITS-1:0]            inB;
  } bundle_t;

  function automatic logic [DEF_DBITS-1:0] sext_imm(input logic [DEF_IMM_BITS-1:0] imm);
    return {{(DEF_DBITS-DEF_IMM_BITS){imm[DEF_IMM_BITS-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// alu_regfile
//   Architectural register file: 2^REG_INDEX_BIT_WIDTH x DBITS, cleared on
//   reset, one synchronous write port and two combinational read ports with
//   same-cycle write bypass.
//   Optional build macro ZERO_REG_EN: register 0 reads as zero, writes to
//   index 0 are dropped and index 0 is never bypassed.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_idx/wr_data  write port
//   rd_idx_a/rd_data_a    read port A
//   rd_idx_b/rd_data_b    read port B
module alu_regfile
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned DBITS               = DEF_DBITS,
  parameter int unsigned REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] wr_idx,
  input  logic [DBITS-1:0]               wr_data,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rd_idx_a,
  output logic [DBITS-1:0]               rd_data_a,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rd_idx_b,
  output logic [DBITS-1:0]               rd_data_b
);

  localparam int unsigned NREGS = 1 << REG_INDEX_BIT_WIDTH;

  logic [DBITS-1:0] regs_q [NREGS];
  logic [DBITS-1:0] regs_d [NREGS];
  logic             wr_en_eff;

`ifdef ZERO_REG_EN
  // Dropping the write here also removes the index-0 bypass below.
  assign wr_en_eff = wr_en && (wr_idx != '0);
`else
  assign wr_en_eff = wr_en;
`endif

  always_comb begin
    regs_d = regs_q;
    if (wr_en_eff) begin
      regs_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data_a = (wr_en_eff && (wr_idx == rd_idx_a)) ? wr_data : regs_q[rd_idx_a];
    rd_data_b = (wr_en_eff && (wr_idx == rd_idx_b)) ? wr_data : regs_q[rd_idx_b];
`ifdef ZERO_REG_EN
    if (rd_idx_a == '0) rd_data_a = '0;
    if (rd_idx_b == '0) rd_data_b = '0;
`endif
  end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Operand-fetch stage in front of the ALU. Reads rs1 and rs2 (or a
//   sign-extended immediate) from the register file with writeback bypass,
//   and presents a registered {aluOp, inA, inB} bundle through a valid/ready
//   handshake backed by a 2-entry skid buffer. in_ready is a flop, so
//   out_ready never reaches upstream combinationally.
//   Optional build macro ZERO_REG_EN (see alu_regfile).
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               upstream handshake
//   in_aluOp, in_rs1, in_rs2,
//   in_imm, in_useImm               instruction fields
//   wb_en/wb_idx/wb_data            register writeback
//   out_valid/out_ready             ALU-side handshake
//   out_aluOp, out_inA, out_inB     registered bundle
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned OPCODE_BIT_WIDTH    = DEF_OPCODE_BIT_WIDTH,
  parameter int unsigned DBITS               = DEF_DBITS,
  parameter int unsigned REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
  parameter int unsigned IMM_BITS            = DEF_IMM_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [OPCODE_BIT_WIDTH-1:0]    in_aluOp,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rs2,
  input  logic [IMM_BITS-1:0]            in_imm,
  input  logic                           in_useImm,
  input  logic                           wb_en,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_idx,
  input  logic [DBITS-1:0]               wb_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OPCODE_BIT_WIDTH-1:0]    out_aluOp,
  output logic [DBITS-1:0]               out_inA,
  output logic [DBITS-1:0]               out_inB
);

  buf_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;
  bundle_t    out_q, out_d;
  bundle_t    skid_q, skid_d;
  bundle_t    new_bundle;

  logic [DBITS-1:0] rd_a;
  logic [DBITS-1:0] rd_b;
  logic             accept;

  alu_regfile #(
    .DBITS               (DBITS),
    .REG_INDEX_BIT_WIDTH (REG_INDEX_BIT_WIDTH)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wb_en),
    .wr_idx    (wb_idx),
    .wr_data   (wb_data),
    .rd_idx_a  (in_rs1),
    .rd_data_a (rd_a),
    .rd_idx_b  (in_rs2),
    .rd_data_b (rd_b)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    new_bundle       = '0;
    new_bundle.aluOp = in_aluOp;
    new_bundle.inA   = rd_a;
    new_bundle.inB   = in_useImm ? sext_imm(in_imm) : rd_b;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = new_bundle;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !out_ready) begin
          skid_d  = new_bundle;
          state_d = ST_TWO;
        end else if (accept && out_ready) begin
          out_d   = new_bundle;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready_q is low here, so nothing new can arrive this cycle.
        if (out_ready) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_aluOp = out_q.aluOp;
  assign out_inA   = out_q.inA;
  assign out_inB   = out_q.inB;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_aluOp;
  logic [3:0]  in_rs1;
  logic [3:0]  in_rs2;
  logic [15:0] in_imm;
  logic        in_useImm;
  logic        wb_en;
  logic [3:0]  wb_idx;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluOp;
  logic [31:0] out_inA;
  logic [31:0] out_inB;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  alu_operand_stage #(
    .OPCODE_BIT_WIDTH    (4),
    .DBITS               (32),
    .REG_INDEX_BIT_WIDTH (4),
    .IMM_BITS            (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_aluOp  (in_aluOp),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .in_useImm (in_useImm),
    .wb_en     (wb_en),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_aluOp (out_aluOp),
    .out_inA   (out_inA),
    .out_inB   (out_inB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic use_imm, input logic [15:0] imm);
    in_valid  = 1'b1;
    in_aluOp  = op;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_useImm = use_imm;
    in_imm    = imm;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r0_exp;
    rst_n = 1'b1; in_valid = 1'b0; in_aluOp = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_useImm = 1'b0; wb_en = 1'b0; wb_idx = '0; wb_data = '0;
    out_ready = 1'b1;

    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_aluOp",     {28'b0, out_aluOp}, 32'd0);
    check("rst_inA",       out_inA, 32'd0);
    check("rst_inB",       out_inB, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Load R3 and R5, then read both.
    wb_en = 1'b1; wb_idx = 4'd3; wb_data = 32'h0000_00AA; tick();
    wb_idx = 4'd5; wb_data = 32'h0000_0055; tick();
    wb_en = 1'b0;
    issue(4'b0001, 4'd3, 4'd5, 1'b0, 16'h0);
    tick();
    in_valid = 1'b0;
    check("rr_valid", {31'b0, out_valid}, 32'd1);
    check("rr_aluOp", {28'b0, out_aluOp}, 32'h1);
    check("rr_inA",   out_inA, 32'h0000_00AA);
    check("rr_inB",   out_inB, 32'h0000_0055);

    // Negative immediate is sign-extended.
    issue(4'd2, 4'd3, 4'd5, 1'b1, 16'h8001);
    tick();
    in_valid = 1'b0;
    check("imm_inA",   out_inA, 32'h0000_00AA);
    check("imm_inB",   out_inB, 32'hFFFF_8001);
    check("imm_aluOp", {28'b0, out_aluOp}, 32'h2);

    // Same-cycle writeback bypass, then stored value visible later.
    wb_en = 1'b1; wb_idx = 4'd7; wb_data = 32'h0000_1234;
    issue(4'd6, 4'd7, 4'd3, 1'b0, 16'h0);
    tick();
    wb_en = 1'b0;
    check("byp_inA", out_inA, 32'h0000_1234);
    check("byp_inB", out_inB, 32'h0000_00AA);
    issue(4'd6, 4'd7, 4'd7, 1'b0, 16'h0);
    tick();
    in_valid = 1'b0;
    check("r7_inA", out_inA, 32'h0000_1234);
    check("r7_inB", out_inB, 32'h0000_1234);
    tick();
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: three back-to-back bundles with out_ready low.
    out_ready = 1'b0;
    issue(4'd3, 4'd3, 4'd0, 1'b1, 16'd1);
    tick();
    check("bp1_in_ready", {31'b0, in_ready}, 32'd1);
    issue(4'd4, 4'd3, 4'd0, 1'b1, 16'd2);
    tick();
    check("bp2_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp2_aluOp",    {28'b0, out_aluOp}, 32'd3);
    issue(4'd5, 4'd3, 4'd0, 1'b1, 16'd3);
    tick();
    check("bp_hold_aluOp", {28'b0, out_aluOp}, 32'd3);
    check("bp_hold_inB",   out_inB, 32'd1);
    check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("bp_o2_aluOp", {28'b0, out_aluOp}, 32'd4);
    check("bp_o2_inB",   out_inB, 32'd2);
    check("bp_o2_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_o3_aluOp", {28'b0, out_aluOp}, 32'd5);
    check("bp_o3_inB",   out_inB, 32'd3);
    check("bp_o3_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("bp_end_valid", {31'b0, out_valid}, 32'd0);

    // Streaming at full rate.
    for (int i = 0; i < 6; i++) begin
      issue(4'(i), 4'd5, 4'd0, 1'b1, 16'(i + 16));
      tick();
      check("st_valid", {31'b0, out_valid}, 32'd1);
      check("st_aluOp", {28'b0, out_aluOp}, 32'(i));
      check("st_inB",   out_inB, 32'(i + 16));
      check("st_ready", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();

    // Register 0 behaviour.
    wb_en = 1'b1; wb_idx = 4'd0; wb_data = 32'h0000_FFFF;
    tick();
    wb_en = 1'b0;
    issue(4'd1, 4'd0, 4'd0, 1'b0, 16'h0);
    tick();
    in_valid = 1'b0;
`ifdef ZERO_REG_EN
    r0_exp = 32'h0;
`else
    r0_exp = 32'h0000_FFFF;
`endif
    check("r0_inA", out_inA, r0_exp);
    tick();

    // Reset while both slots are full.
    out_ready = 1'b0;
    issue(4'd9, 4'd3, 4'd0, 1'b1, 16'd7);
    tick();
    issue(4'd10, 4'd3, 4'd0, 1'b1, 16'd8);
    tick();
    in_valid = 1'b0;
    check("two_in_ready", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_ready", {31'b0, in_ready},  32'd1);
    check("mrst_inA",   out_inA, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_valid", {31'b0, out_valid}, 32'd0);
    issue(4'd1, 4'd3, 4'd5, 1'b0, 16'h0);
    tick();
    in_valid = 1'b0;
    check("post_rst_r3", out_inA, 32'd0);
    check("post_rst_r5", out_inB, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
